axis_command_arbiter: RTL and testbench

- Shares one 72-bit AXI4-Stream command path (peripheral write commands) between NUM_PORTS requesters.
- Round-robin arbitration.
- Enforces a programmable minimum idle gap after every forwarded command.
- Sits between the per-source command formatters and the single serial-peripheral command sink.

---
 rtl/axis_command_arbiter_if.sv | 35 +++
 rtl/axis_command_arbiter.sv | 93 +++++++++
 tb/tb_axis_command_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_command_arbiter_if.sv
// axis_command_arbiter_if: command streams around the arbiter (per-port slave streams and the shared master stream).
// Defining AXIS_ARBITER_LOCK_EN adds the per-port s_axis_tlast signal.
interface axis_command_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 72
);
    logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS-1:0]            s_axis_tvalid;
    logic [NUM_PORTS-1:0]            s_axis_tready;
`ifdef AXIS_ARBITER_LOCK_EN
    logic [NUM_PORTS-1:0]            s_axis_tlast;
`endif
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic                            m_axis_tvalid;
    logic                            m_axis_tready;
`ifdef AXIS_ARBITER_LOCK_EN
    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
`else
    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
`endif
endinterface

// File: rtl/axis_command_arbiter.sv
// axis_command_arbiter: round-robin merge of NUM_PORTS command streams with a programmable idle gap after each command.
// Defining AXIS_ARBITER_LOCK_EN keeps the grant on a port until its tlast beat has been forwarded.
module axis_command_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 72,
    parameter int CNTR_WIDTH = 32
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] cfg_data,
    output logic [31:0] sts_data,
    axis_command_arbiter_if.master axis
);
    localparam int PTR_W = $clog2(NUM_PORTS);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t                state_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [CNTR_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic [31:0]           sts_q;
    logic [NUM_PORTS-1:0]  req;
    logic [PTR_W-1:0]      idx;
    logic [PTR_W-1:0]      gnt;
    logic                  found;
    logic [DATA_WIDTH-1:0] gnt_data;
`ifdef AXIS_ARBITER_LOCK_EN
    logic                  lock_q;
    logic [PTR_W-1:0]      lock_port_q;
    assign req = lock_q ? (axis.s_axis_tvalid & (NUM_PORTS'(1) << lock_port_q)) : axis.s_axis_tvalid;
`else
    assign req = axis.s_axis_tvalid;
`endif
    // Scan downward so the last hit is the requester closest to ptr_q.
    always_comb begin
        found = 1'b0;
        gnt = '0;
        idx = '0;
        gnt_data = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
            if (req[idx]) begin
                found = 1'b1;
                gnt = idx;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt == PTR_W'(i)) gnt_data = axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    assign axis.s_axis_tready = (!areset && state_q == IDLE && found) ? (NUM_PORTS'(1) << gnt) : '0;
    assign axis.m_axis_tdata  = tdata_q;
    assign axis.m_axis_tvalid = tvalid_q;
    assign sts_data           = sts_q;
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            sts_q       <= '0;
`ifdef AXIS_ARBITER_LOCK_EN
            lock_q      <= 1'b0;
            lock_port_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    tdata_q     <= gnt_data;
                    tvalid_q    <= 1'b1;
                    ptr_q       <= (gnt == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
`ifdef AXIS_ARBITER_LOCK_EN
                    lock_q      <= !axis.s_axis_tlast[gnt];
                    lock_port_q <= gnt;
`endif
                    state_q     <= SEND;
                end
                SEND: if (axis.m_axis_tready) begin
                    tvalid_q <= 1'b0;
                    sts_q    <= sts_q + 32'd1;
                    cnt_q    <= cfg_data[CNTR_WIDTH-1:0];
                    state_q  <= (cfg_data[CNTR_WIDTH-1:0] == '0) ? IDLE : GAP;
                end
                GAP: begin
                    cnt_q   <= cnt_q - 1'b1;
                    state_q <= (cnt_q == CNTR_WIDTH'(1)) ? IDLE : GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_command_arbiter.sv
// tb_axis_command_arbiter: table vectors, directed corner sequences and a randomized run against a transaction-level model.
// Build with AXIS_ARBITER_LOCK_EN defined to also exercise the lock feature.
module tb_axis_command_arbiter;
    localparam int NP = 2;
    localparam int DW = 72;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] cfg_data = '0;
    logic [31:0] sts_data;
    int          checks = 0;
    int          failures = 0;
    axis_command_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();
    axis_command_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CNTR_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset), .cfg_data(cfg_data), .sts_data(sts_data), .axis(bus)
    );
    always #5 aclk = ~aclk;

    typedef struct {
        logic [NP-1:0] vld;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [31:0]   cfg;
        int            gnt;
    } vec_t;
    vec_t            tbl[7];
    int              gq[$];
    int              hq[$];
    logic [NP-1:0]   rq[$];
    int              exp_lock[4] = '{0, 0, 0, 1};
    int              mh, last, beat;
    logic [31:0]     exp_sts;
    // reference model state for the randomized run
    bit              m_pend, m_lock;
    int              m_start, m_lock_port, m_elig, m_pick;
    logic [DW-1:0]   m_data;
    logic [31:0]     m_cnt;
    logic [NP-1:0]   m_ready;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge aclk);
        #1;
    endtask
    task automatic smp();
        @(negedge aclk);
    endtask
    function automatic int oh2i(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction
    function automatic logic [DW-1:0] rnd72();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{2'b01, 72'h25_0000_14_1234_11_5678, 72'h1, 0, 0};
        tbl[1] = '{2'b11, 72'hAA_0000_0000_0000_0001, 72'hBB_0000_0000_0000_0002, 0, 1};
        tbl[2] = '{2'b11, 72'hAA_0000_0000_0000_0003, 72'hBB_0000_0000_0000_0004, 3, 0};
        tbl[3] = '{2'b10, 72'hAA_0000_0000_0000_0005, 72'hBB_0000_0000_0000_0006, 0, 1};
        tbl[4] = '{2'b10, 72'hAA_0000_0000_0000_0007, 72'hBB_0000_0000_0000_0008, 1, 1};
        tbl[5] = '{2'b01, 72'hAA_0000_0000_0000_0009, 72'hBB_0000_0000_0000_000A, 0, 0};
        tbl[6] = '{2'b11, 72'hFF_FFFF_FFFF_FFFF_FFFF, 72'h80_0000_0000_0000_0001, 2, 1};
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = '0;
        bus.m_axis_tready = 1'b1;
`ifdef AXIS_ARBITER_LOCK_EN
        bus.s_axis_tlast  = '1;
`endif
        // reset state and ready gating while reset is held
        step();
        bus.s_axis_tvalid = 2'b11;
        smp();
        chk("reset_sready", bus.s_axis_tready, 0);
        step();
        smp();
        chk("reset_mvalid", bus.m_axis_tvalid, 0);
        chk("reset_mdata", bus.m_axis_tdata, 0);
        chk("reset_sts", sts_data, 0);
        step();
        areset = 1'b0;
        bus.s_axis_tvalid = '0;
        exp_sts = 0;
        // table-driven single beats
        for (int i = 0; i < 7; i++) begin
            bus.s_axis_tvalid = tbl[i].vld;
            bus.s_axis_tdata  = {tbl[i].d1, tbl[i].d0};
            cfg_data          = tbl[i].cfg;
            smp();
            chk($sformatf("tbl%0d_sready", i), bus.s_axis_tready, NP'(1) << tbl[i].gnt);
            step();
            bus.s_axis_tvalid = '0;
            smp();
            chk($sformatf("tbl%0d_mvalid", i), bus.m_axis_tvalid, 1);
            chk($sformatf("tbl%0d_mdata", i), bus.m_axis_tdata, (tbl[i].gnt == 1) ? tbl[i].d1 : tbl[i].d0);
            step();
            exp_sts++;
            smp();
            chk($sformatf("tbl%0d_mvalid_clr", i), bus.m_axis_tvalid, 0);
            chk($sformatf("tbl%0d_sts", i), sts_data, exp_sts);
            repeat (tbl[i].cfg + 1) step();
        end
        // round-robin fairness with both ports requesting
        bus.s_axis_tdata  = {72'h11, 72'h22};
        bus.s_axis_tvalid = 2'b11;
        cfg_data = 0;
        mh = 0;
        for (int c = 0; c < 40 && mh < 8; c++) begin
            smp();
            if (|bus.s_axis_tready) gq.push_back(oh2i(bus.s_axis_tready));
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                hq.push_back(c);
                mh++;
            end
            step();
        end
        bus.s_axis_tvalid = '0;
        chk("rr_grants", gq.size(), 8);
        chk("rr_handshakes", mh, 8);
        for (int k = 0; k < gq.size(); k++) chk($sformatf("rr_order%0d", k), gq[k], k % NP);
        for (int k = 1; k < hq.size(); k++) chk("rr_spacing", hq[k] - hq[k-1], 2);
        exp_sts += 8;
        smp();
        chk("rr_sts", sts_data, exp_sts);
        step();
        // gap enforcement; cfg_data is disturbed inside each gap and must be ignored
        gq.delete();
        hq.delete();
        bus.s_axis_tvalid = 2'b10;
        mh = 0;
        last = -100;
        for (int c = 0; c < 60 && mh < 4; c++) begin
            cfg_data = (c > last && c <= last + 3) ? 2 : 5;
            smp();
            rq.push_back(bus.s_axis_tready);
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                hq.push_back(c);
                last = c;
                mh++;
            end
            step();
        end
        bus.s_axis_tvalid = '0;
        cfg_data = 0;
        chk("gap_handshakes", mh, 4);
        for (int k = 1; k < hq.size(); k++) chk("gap_spacing", hq[k] - hq[k-1], 7);
        for (int k = 0; k + 1 < hq.size(); k++) begin
            for (int j = 1; j <= 5; j++) chk("gap_sready", rq[hq[k]+j], 0);
            chk("gap_regrant", rq[hq[k]+6], 2'b10);
        end
        repeat (8) step();
        exp_sts += 4;
        // backpressure
        bus.s_axis_tdata  = {72'h99, 72'h12_3456_789A_BCDE_F012};
        bus.s_axis_tvalid = 2'b01;
        bus.m_axis_tready = 1'b0;
        smp();
        chk("bp_sready", bus.s_axis_tready, 2'b01);
        step();
        bus.s_axis_tvalid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            smp();
            chk("bp_mvalid", bus.m_axis_tvalid, 1);
            chk("bp_mdata", bus.m_axis_tdata, 72'h12_3456_789A_BCDE_F012);
            chk("bp_sready", bus.s_axis_tready, 0);
            chk("bp_sts", sts_data, exp_sts);
            step();
        end
        bus.m_axis_tready = 1'b1;
        step();
        bus.s_axis_tvalid = '0;
        exp_sts++;
        smp();
        chk("bp_sts_after", sts_data, exp_sts);
        chk("bp_mvalid_after", bus.m_axis_tvalid, 0);
        step();
        // reset during GAP, then during SEND; port 0 must win each time
        bus.s_axis_tvalid = 2'b01;
        cfg_data = 100;
        smp();
        chk("rg_sready", bus.s_axis_tready, 2'b01);
        step();
        bus.s_axis_tvalid = '0;
        step();
        repeat (5) step();
        bus.s_axis_tvalid = 2'b11;
        smp();
        chk("rg_gap_sready", bus.s_axis_tready, 0);
        areset = 1'b1;
        step();
        areset = 1'b0;
        smp();
        chk("rg_mvalid", bus.m_axis_tvalid, 0);
        chk("rg_sts", sts_data, 0);
        chk("rg_port0_wins", bus.s_axis_tready, 2'b01);
        bus.m_axis_tready = 1'b0;
        step();
        smp();
        chk("rs_mvalid_pre", bus.m_axis_tvalid, 1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        smp();
        chk("rs_mvalid", bus.m_axis_tvalid, 0);
        chk("rs_port0_wins", bus.s_axis_tready, 2'b01);
        bus.m_axis_tready = 1'b1;
        step();
        bus.s_axis_tvalid = '0;
        repeat (3) step();
`ifdef AXIS_ARBITER_LOCK_EN
        // port 0 sends a 3-beat packet while port 1 requests continuously
        areset = 1'b1;
        cfg_data = 0;
        step();
        areset = 1'b0;
        gq.delete();
        beat = 0;
        for (int c = 0; c < 40 && gq.size() < 4; c++) begin
            bus.s_axis_tvalid = {1'b1, beat < 3};
            bus.s_axis_tlast  = {1'b1, beat == 2};
            smp();
            if (|bus.s_axis_tready) begin
                gq.push_back(oh2i(bus.s_axis_tready));
                if (bus.s_axis_tready[0]) beat++;
            end
            step();
        end
        bus.s_axis_tvalid = '0;
        chk("lock_grants", gq.size(), 4);
        for (int k = 0; k < gq.size() && k < 4; k++) chk($sformatf("lock_order%0d", k), gq[k], exp_lock[k]);
        repeat (3) step();
`endif
        // randomized traffic against a transaction-level model
        areset = 1'b1;
        step();
        areset = 1'b0;
        m_pend = 0;
        m_lock = 0;
        m_start = 0;
        m_lock_port = 0;
        m_elig = 0;
        m_cnt = 0;
        m_data = '0;
        for (int n = 0; n < 3000; n++) begin
            bus.s_axis_tvalid = NP'($urandom);
            for (int p = 0; p < NP; p++) bus.s_axis_tdata[p*DW +: DW] = rnd72();
`ifdef AXIS_ARBITER_LOCK_EN
            bus.s_axis_tlast = NP'($urandom);
`endif
            bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            cfg_data = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            smp();
            m_pick = -1;
            if (!m_pend && n >= m_elig) begin
                for (int k = NP - 1; k >= 0; k--) begin
                    if (bus.s_axis_tvalid[(m_start + k) % NP] && (!m_lock || (m_start + k) % NP == m_lock_port))
                        m_pick = (m_start + k) % NP;
                end
            end
            m_ready = (m_pick >= 0) ? NP'(1) << m_pick : '0;
            chk("rnd_sready", bus.s_axis_tready, m_ready);
            chk("rnd_mvalid", bus.m_axis_tvalid, m_pend);
            if (m_pend) chk("rnd_mdata", bus.m_axis_tdata, m_data);
            chk("rnd_sts", sts_data, m_cnt);
            if (m_pend && bus.m_axis_tready) begin
                m_pend = 0;
                m_cnt++;
                m_elig = n + 1 + int'(cfg_data);
            end else if (m_pick >= 0) begin
                m_pend = 1;
                m_data = bus.s_axis_tdata[m_pick*DW +: DW];
                m_start = (m_pick + 1) % NP;
`ifdef AXIS_ARBITER_LOCK_EN
                m_lock = !bus.s_axis_tlast[m_pick];
                m_lock_port = m_pick;
`endif
            end
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
